// File: rtl/barrelshifter_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, with a global stall and flush.
// Optional sticky output (OR of bits shifted out by SRL/SRA) when BARRELSHIFTER_PIPE_STICKY_EN is defined.
module barrelshifter_pipe #(
  parameter int WIDTH = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       rx_enable,
  input  logic                       rx_flush,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  input  logic [2:0]                 rx_op,
  input  logic [WIDTH-1:0]           rx_input,
  input  logic [$clog2(WIDTH)-1:0]   rx_coeff,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [WIDTH-1:0]           tx_shift
`ifdef BARRELSHIFTER_PIPE_STICKY_EN
  ,
  output logic                       tx_sticky
`endif
);

  localparam int LOG2W = $clog2(WIDTH);

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  // A stall freezes every stage at once, so bubbles are never squeezed out.
  logic advance;
  assign advance  = rx_enable & (~tx_valid | tx_ready);
  assign rx_ready = advance;

  genvar k;
  for (k = 0; k < LOG2W; k++) begin : g_stage
    localparam int AMT = 1 << k;
    localparam logic [LOG2W-1:0] SEL_BIT = LOG2W'(1) << k;

    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_shift;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       op_in;
    logic [LOG2W-1:0] coeff_in;
    logic             v_in;
    logic             valid_q;
    logic             sel;
`ifdef BARRELSHIFTER_PIPE_STICKY_EN
    localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << AMT) - WIDTH'(1);
    logic sticky_in;
    logic sticky_q;
`endif

    if (k == 0) begin : g_src
      assign d_in     = rx_input;
      assign op_in    = rx_op;
      assign coeff_in = rx_coeff;
      assign v_in     = rx_valid;
`ifdef BARRELSHIFTER_PIPE_STICKY_EN
      assign sticky_in = 1'b0;
`endif
    end else begin : g_src
      assign d_in     = g_stage[k-1].data_q;
      assign op_in    = g_stage[k-1].g_carry.op_q;
      assign coeff_in = g_stage[k-1].g_carry.coeff_q;
      assign v_in     = g_stage[k-1].valid_q;
`ifdef BARRELSHIFTER_PIPE_STICKY_EN
      assign sticky_in = g_stage[k-1].sticky_q;
`endif
    end

    assign sel = |(coeff_in & SEL_BIT);

    always_comb begin
      d_shift = d_in;
      if (sel) begin
        case (op_in)
          OP_SLL:  d_shift = d_in << AMT;
          OP_SRL:  d_shift = d_in >> AMT;
          OP_SRA:  d_shift = $unsigned($signed(d_in) >>> AMT);
          OP_ROL:  d_shift = (d_in << AMT) | (d_in >> (WIDTH - AMT));
          OP_ROR:  d_shift = (d_in >> AMT) | (d_in << (WIDTH - AMT));
          default: d_shift = d_in;
        endcase
      end
    end

    // Flush only kills valid bits; data may keep stale contents.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        if (advance) data_q <= d_shift;
        if (rx_flush)     valid_q <= 1'b0;
        else if (advance) valid_q <= v_in;
      end
    end

`ifdef BARRELSHIFTER_PIPE_STICKY_EN
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        sticky_q <= 1'b0;
      end else if (advance) begin
        sticky_q <= sticky_in |
                    (sel & ((op_in == OP_SRL) | (op_in == OP_SRA)) & (|(d_in & LOW_MASK)));
      end
    end
`endif

    // The last stage has no successor, so it carries no op or coeff forward.
    if (k < LOG2W - 1) begin : g_carry
      logic [2:0]       op_q;
      logic [LOG2W-1:0] coeff_q;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          op_q    <= 3'b000;
          coeff_q <= '0;
        end else if (advance) begin
          op_q    <= op_in;
          coeff_q <= coeff_in;
        end
      end
    end
  end

  assign tx_valid = g_stage[LOG2W-1].valid_q;
  assign tx_shift = g_stage[LOG2W-1].data_q;
`ifdef BARRELSHIFTER_PIPE_STICKY_EN
  assign tx_sticky = g_stage[LOG2W-1].sticky_q;
`endif

endmodule

// File: tb/tb_barrelshifter_pipe.sv
// Directed self-checking bench for barrelshifter_pipe at WIDTH=16.
// Checks tx_sticky as well when BARRELSHIFTER_PIPE_STICKY_EN is defined.
module tb_barrelshifter_pipe;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        rx_enable;
  logic        rx_flush;
  logic        rx_valid;
  logic        rx_ready;
  logic [2:0]  rx_op;
  logic [15:0] rx_input;
  logic [3:0]  rx_coeff;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_shift;
`ifdef BARRELSHIFTER_PIPE_STICKY_EN
  logic        tx_sticky;
`endif

  int checks = 0;
  int errors = 0;

  barrelshifter_pipe #(.WIDTH(16)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .rx_enable (rx_enable),
    .rx_flush  (rx_flush),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_op     (rx_op),
    .rx_input  (rx_input),
    .rx_coeff  (rx_coeff),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_shift  (tx_shift)
`ifdef BARRELSHIFTER_PIPE_STICKY_EN
    ,
    .tx_sticky (tx_sticky)
`endif
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] din, input logic [3:0] coeff);
    rx_valid = 1'b1;
    rx_op    = op;
    rx_input = din;
    rx_coeff = coeff;
  endtask

  // lat counts edges after the accepting edge; a 4-stage pipe gives 3.
  task automatic wait_out(input string tag, input logic [15:0] exp, input int lat);
    int n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_data"}, {16'd0, tx_shift}, {16'd0, exp});
  endtask

  task automatic run_single(input string tag, input logic [2:0] op, input logic [15:0] din,
                            input logic [3:0] coeff, input logic [15:0] exp);
    drive(op, din, coeff);
    tick();
    rx_valid = 1'b0;
    wait_out(tag, exp, 3);
    tick();
  endtask

  logic [15:0] ror_exp [8] = '{16'h1234, 16'h091A, 16'h048D, 16'h8246,
                               16'h4123, 16'hA091, 16'hD048, 16'h6824};

  initial begin
    int issued;
    int rcv;
    int seen;
    logic [15:0] frozen;

    aresetn = 1'b0; rx_enable = 1'b1; rx_flush = 1'b0; rx_valid = 1'b0;
    rx_op = 3'b000; rx_input = 16'h0; rx_coeff = 4'h0; tx_ready = 1'b1;
    frozen = 16'h0;
    #1;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_shift", {16'd0, tx_shift}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    rx_enable = 1'b0;
    #1;
    chk("rst_rx_ready_dis", {31'd0, rx_ready}, 32'd0);
    rx_enable = 1'b1;
    tick();
    tick();
    aresetn = 1'b1;
    tick();

    run_single("rol_8001_1", 3'b100, 16'h8001, 4'd1, 16'h0003);
    run_single("sra_8000_15", 3'b011, 16'h8000, 4'd15, 16'hFFFF);
    run_single("srl_8000_15", 3'b010, 16'h8000, 4'd15, 16'h0001);
    run_single("sll_0001_15", 3'b001, 16'h0001, 4'd15, 16'h8000);
    run_single("sll_00f0_4", 3'b001, 16'h00F0, 4'd4, 16'h0F00);
    run_single("rol_1234_4", 3'b100, 16'h1234, 4'd4, 16'h2341);
    run_single("sra_7000_4", 3'b011, 16'h7000, 4'd4, 16'h0700);
    run_single("op110_pass", 3'b110, 16'h1234, 4'd5, 16'h1234);
    run_single("sra_coeff0", 3'b011, 16'hABCD, 4'd0, 16'hABCD);

    // Enable low freezes an in-flight op, then a held result.
    drive(3'b010, 16'h00FF, 4'd4);
    tick();
    rx_valid = 1'b0;
    tick();
    rx_enable = 1'b0;
    #1;
    chk("dis_rx_ready", {31'd0, rx_ready}, 32'd0);
    repeat (5) tick();
    chk("dis_no_valid", {31'd0, tx_valid}, 32'd0);
    rx_enable = 1'b1;
    wait_out("srl_00ff_4", 16'h000F, 2);
`ifdef BARRELSHIFTER_PIPE_STICKY_EN
    chk("sticky_srl", {31'd0, tx_sticky}, 32'd1);
`endif
    rx_enable = 1'b0;
    tick();
    chk("dis_hold_valid", {31'd0, tx_valid}, 32'd1);
    chk("dis_hold_data", {16'd0, tx_shift}, 32'h000F);
    rx_enable = 1'b1;
    tick();
    chk("dis_drained", {31'd0, tx_valid}, 32'd0);

    for (int t = 0; t <= 10; t++) begin
      if (t < 8) drive(3'b101, 16'h1234, 4'(t));
      else rx_valid = 1'b0;
      tick();
      if (t >= 3) begin
        chk($sformatf("b2b_valid_%0d", t - 3), {31'd0, tx_valid}, 32'd1);
        chk($sformatf("b2b_data_%0d", t - 3), {16'd0, tx_shift}, {16'd0, ror_exp[t-3]});
      end
    end
    rx_valid = 1'b0;
    tick();

    issued = 0;
    rcv = 0;
    for (int it = 0; it < 40; it++) begin
      tx_ready = !(it >= 6 && it <= 10);
      #1;
      if (tx_valid && tx_ready) begin
        chk($sformatf("stall_data_%0d", rcv), {16'd0, tx_shift}, {16'd0, 16'h0001 << rcv});
        rcv++;
      end
      if (!tx_ready) begin
        chk("stall_tx_valid", {31'd0, tx_valid}, 32'd1);
        chk("stall_rx_ready", {31'd0, rx_ready}, 32'd0);
        if (it == 6) frozen = tx_shift;
        else chk("stall_frozen", {16'd0, tx_shift}, {16'd0, frozen});
      end
      if (rx_ready && issued < 10) begin
        drive(3'b001, 16'h0001, 4'(issued));
        issued++;
      end else begin
        rx_valid = 1'b0;
      end
      tick();
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    chk("stall_count", rcv, 10);

    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 16'h0001, 4'(i + 1));
      tick();
    end
    drive(3'b001, 16'h0003, 4'd2);
    rx_flush = 1'b1;
    tick();
    rx_flush = 1'b0;
    rx_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (tx_valid) seen++;
      tick();
    end
    chk("flush_no_output", seen, 0);
    run_single("post_flush_ror", 3'b101, 16'h1234, 4'd4, 16'h4123);

    for (int i = 0; i < 5; i++) begin
      drive(3'b001, 16'h0001, 4'(i));
      tick();
    end
    rx_valid = 1'b0;
    chk("prerst_valid", {31'd0, tx_valid}, 32'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_tx_shift", {16'd0, tx_shift}, 32'd0);
    chk("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
    tick();
    tick();
    aresetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_valid) seen++;
    end
    chk("postrst_no_stale", seen, 0);
    run_single("postrst_srl", 3'b010, 16'hF000, 4'd12, 16'h000F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
